// File: rtl/uart_pkg.sv
// Shared types and helpers for the string UART transmitter.
// UART_STR_TX_PARITY_EN adds the even-parity state to the encoding.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 104;

`ifdef UART_STR_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, STOP, FIN, PARITY
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, STOP, FIN
    } state_t;
`endif

    // Floor of log2(v); returns 0 for v <= 1.
    function automatic int flog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (v >= (1 << i)) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick on the last cycle of each UART bit,
// restarted from zero by clr.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = flog2(CLKS_PER_BIT - 1) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_str_tx.sv
// Sends a string of len characters from an external BRAM over a UART line.
// Define UART_STR_TX_PARITY_EN for 8E1 framing; default build is 8N1.
module uart_str_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int LEN          = 256,
    parameter int TXSTR_BASE   = LEN / 2,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    localparam int AW          = flog2(LEN - 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    len,
    output logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] dout,
    output logic             TX,
    output logic             busy,
    output logic             done
);
    localparam int BW = flog2(WIDTH - 1) + 1;
    localparam logic [AW-1:0] BASE      = AW'(TXSTR_BASE % LEN);
    localparam logic [AW-1:0] ADDR_LAST = AW'(LEN - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    len_q, len_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AW:0]      idx_nxt;
    logic             tick;
    logic             clr;
`ifdef UART_STR_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign idx_nxt = {1'b0, idx_q} + (AW+1)'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        bit_d   = bit_q;
`ifdef UART_STR_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        idx_d   = '0;
                        addr_d  = BASE;
                        state_d = FETCH;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                shift_d = dout;
`ifdef UART_STR_TX_PARITY_EN
                par_d   = ^dout;
`endif
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_STR_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_STR_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP: begin
                if (tick) begin
                    if (idx_nxt < {1'b0, len_q}) begin
                        idx_d   = idx_nxt[AW-1:0];
                        addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so TX changes with the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_STR_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == FIN);
    end

    assign clr = (state_d != state_q);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_STR_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_STR_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign addr = addr_q;
    assign TX   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_str_tx.sv
// Scoreboard bench for uart_str_tx: two instances (string base 128 and 254)
// with one-cycle-latency BRAM models; a line monitor decodes and checks frames.
module tb_uart_str_tx;

`ifdef UART_STR_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int CPB = 4;
    localparam int PER = 2 + NB * CPB;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        int         abort_idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic [7:0] len_drv;
    logic       start_a, start_b;
    logic [7:0] addr_a, addr_b, dout_a, dout_b;
    logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic       mon_tx, mon_busy, mon_done;
    logic [7:0] mon_addr;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        dout_a <= mem_a[addr_a];
        dout_b <= mem_b[addr_b];
    end

    assign start_a  = start & ~sel;
    assign start_b  = start & sel;
    assign mon_tx   = sel ? tx_b   : tx_a;
    assign mon_busy = sel ? busy_b : busy_a;
    assign mon_done = sel ? done_b : done_a;
    assign mon_addr = sel ? addr_b : addr_a;

    uart_str_tx #(.WIDTH(8), .LEN(256), .TXSTR_BASE(128), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .len(len_drv), .addr(addr_a),
        .dout(dout_a), .TX(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_str_tx #(.WIDTH(8), .LEN(256), .TXSTR_BASE(254), .CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .len(len_drv), .addr(addr_b),
        .dout(dout_b), .TX(tx_b), .busy(busy_b), .done(done_b)
    );

    function automatic void chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Expected per-cycle line samples of one frame; samples from abort_idx on are idle-high.
    function automatic logic [43:0] frame_samples(input logic [7:0] d, input int abort_idx);
        logic [43:0] v;
        logic        b;
        v = '1;
        for (int j = 0; j < NB * CPB; j++) begin
            int k;
            k = j / CPB;
            if (k == 0)                  b = 1'b0;
            else if (k <= 8)             b = d[k-1];
            else if (NB == 11 && k == 9) b = ^d;
            else                         b = 1'b1;
            v[j] = (j >= abort_idx) ? 1'b1 : b;
        end
        return v;
    endfunction

    // Line monitor: a low sample starts a frame; pop the scoreboard and compare.
    int          m_s;
    logic [43:0] m_got;
    exp_t        m_e;
    always begin
        @(negedge clk);
        if (mon_tx === 1'b0) begin
            m_s      = cyc;
            m_got    = '1;
            m_got[0] = 1'b0;
            for (int j = 1; j < NB * CPB; j++) begin
                @(negedge clk);
                m_got[j] = mon_tx;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", m_s, -1);
            end else begin
                m_e = exp_q.pop_front();
                chk("frame_start_cycle", m_s, m_e.cyc);
                chk("frame_bits", m_got, frame_samples(m_e.data, m_e.abort_idx));
                $display("frame: start cycle %0d, expected data %02h, samples %011h",
                         m_s, m_e.data, m_got);
            end
        end
    end

    task automatic send(input bit s, input int n, input int base);
        int tacc, done_cyc, ndone, busy_bad, txlow, lim;
        bit seen;
        sel = s;
        @(posedge clk); #1;
        start   = 1'b1;
        len_drv = 8'(n);
        @(posedge clk); #1;
        start   = 1'b0;
        len_drv = 8'hA5;
        tacc    = cyc;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{data: s ? mem_b[(base + i) % 256] : mem_a[(base + i) % 256],
                              cyc: tacc + 2 + i * PER, abort_idx: NB * CPB});
        end
        $display("send: dut %0d len %0d accepted, first cycle %0d", s, n, tacc);
        done_cyc = -1; ndone = 0; busy_bad = 0; txlow = 0; seen = 1'b0;
        lim = n * PER + 12;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (k == 0 && n == 0) begin start = 1'b1; len_drv = 8'd1; end
            if (k == 5 && n > 0)  begin start = 1'b1; len_drv = 8'd7; end
            if (k == 1 || k == 6) start = 1'b0;
            if (n > 0 && (k % PER) == 0 && (k / PER) < n)
                chk("fetch_addr", mon_addr, (base + k / PER) % 256);
            if (mon_done) begin
                ndone++;
                if (!seen) begin
                    seen     = 1'b1;
                    done_cyc = cyc;
                    if (mon_busy) busy_bad++;
                end
            end else if (!seen && !mon_busy) begin
                busy_bad++;
            end else if (seen && mon_busy) begin
                busy_bad++;
            end
            if (mon_tx !== 1'b1) txlow++;
        end
        chk("done_cycle", done_cyc, tacc + n * PER + 1);
        chk("done_count", ndone, 1);
        chk("busy_window", busy_bad, 0);
        if (n == 0) chk("tx_idle_len0", txlow, 0);
    endtask

    initial begin
        int tacc, s2, ndone, busy_bad;
        rst = 1'b1; start = 1'b0; sel = 1'b0; len_drv = 8'd0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_a", tx_a, 1);
        chk("reset_tx_b", tx_b, 1);
        chk("reset_busy_a", busy_a, 0);
        chk("reset_done_a", done_a, 0);
        chk("reset_addr_a", addr_a, 0);
        chk("reset_addr_b", addr_b, 0);
        rst = 1'b0;

        mem_a[128] = 8'h41;
        send(1'b0, 1, 128);

        mem_a[128] = 8'h61; mem_a[129] = 8'h62; mem_a[130] = 8'h63;
        send(1'b0, 3, 128);

        send(1'b0, 0, 128);

        mem_b[254] = 8'h11; mem_b[255] = 8'h22; mem_b[0] = 8'h33; mem_b[1] = 8'h44;
        send(1'b1, 4, 254);

        // Reset during bit 2 of the third character (0x63 has a 0 there).
        sel = 1'b0;
        mem_a[131] = 8'h64;
        @(posedge clk); #1;
        start = 1'b1; len_drv = 8'd4;
        @(posedge clk); #1;
        start = 1'b0; tacc = cyc;
        s2 = tacc + 2 + 2 * PER;
        exp_q.push_back('{data: mem_a[128], cyc: tacc + 2,       abort_idx: NB * CPB});
        exp_q.push_back('{data: mem_a[129], cyc: tacc + 2 + PER, abort_idx: NB * CPB});
        exp_q.push_back('{data: mem_a[130], cyc: s2,             abort_idx: 14});
        $display("send: dut 0 len 4 accepted, first cycle %0d, reset planned", tacc);
        while (cyc < s2 + 13) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_tx_high", tx_a, 1);
        chk("abort_busy_low", busy_a, 0);
        chk("abort_addr_zero", addr_a, 0);
        ndone = 0; busy_bad = 0;
        repeat (NB * CPB + 8) begin
            @(negedge clk);
            if (done_a) ndone++;
            if (busy_a) busy_bad++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_busy_idle", busy_bad, 0);
        send(1'b0, 1, 128);

        mem_a[128] = 8'h07; mem_a[129] = 8'h03;
        send(1'b0, 2, 128);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_str_tx.md
UART_STR_TX -- requirements
Module: uart_str_tx

Interface
REQ-001 The module SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 8, data bits per character and BRAM word width.
- LEN, 256, BRAM depth; address width AW = log2(LEN-1)+1.
- TXSTR_BASE, LEN/2, BRAM address of character 0 of the outgoing string.
- CLKS_PER_BIT, 104, clk cycles per UART bit; legal values are 2 or more.

REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, the single clock; all logic is on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle request to send a string; driven from msg_valid.
- len, input, AW, number of characters to send; sampled only in the cycle start is accepted.
- addr, output, AW, BRAM read address.
- dout, input, WIDTH, BRAM read data; valid one cycle after addr.
- TX, output, 1, UART line; idles high.
- busy, output, 1, high from acceptance of start until the done cycle.
- done, output, 1, one-cycle pulse when the string is finished.

Function
REQ-003 Each character SHALL be framed 8N1: start bit 0, then WIDTH data bits LSB first, then stop bit 1; each bit is held for exactly CLKS_PER_BIT cycles.
REQ-004 The FSM SHALL have these states: IDLE, FETCH, LATCH, START, DATA, STOP, FIN.
REQ-005 In IDLE with start=1 and len>0, the module SHALL capture len, clear the index, and move to FETCH; busy rises in the next cycle.
REQ-006 In IDLE with start=1 and len=0, the module SHALL go to FIN; TX stays high and done pulses two cycles after start.
REQ-007 In FETCH, addr SHALL equal (TXSTR_BASE + index) mod LEN; in LATCH, dout SHALL be registered into the shift register.
REQ-008 The first start bit SHALL begin 3 cycles after the start cycle.
REQ-009 After STOP of character i: if i+1 < len, go to FETCH; otherwise go to FIN.
REQ-010 Between characters, the line SHALL stay high for exactly 2 extra cycles (FETCH, LATCH); no other gap is allowed.
REQ-011 FIN SHALL last one cycle, assert done=1, and return to IDLE with busy=0 in the same cycle.
REQ-012 A start pulse while busy=1 SHALL be ignored; len changes while busy SHALL have no effect.
REQ-013 A start pulse in the FIN cycle SHALL be ignored; start is accepted only in IDLE.
REQ-014 The index counter SHALL be AW bits wide. Address arithmetic SHALL wrap modulo LEN, so strings that run past LEN-1 continue at address 0.
REQ-015 TX SHALL be driven from a register, so it is glitch-free.
REQ-016 addr SHALL hold its last value outside FETCH.

Reset
REQ-017 With rst=1 at a clock edge, the next state SHALL be: IDLE, TX=1, busy=0, done=0, addr=0, index=0, baud counter=0.
REQ-018 Reset in the middle of a frame SHALL abort the transfer at once; no done pulse is issued and TX returns high on the next cycle.
REQ-019 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-020 With UART_STR_TX_PARITY_EN defined, a PARITY state SHALL be added between DATA and STOP. It sends the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles, making the frame 8E1.
REQ-021 With UART_STR_TX_PARITY_EN undefined, there SHALL be no PARITY state and no parity logic; the frame is 8N1.

Structure
REQ-022 A shared package uart_pkg SHALL hold the state encoding constants, the default CLKS_PER_BIT, and the log2 helper function.
REQ-023 The module SHALL contain one sub-module, uart_baud_tick. It counts to CLKS_PER_BIT-1, restarts when it is cleared on each state entry, and gives a one-cycle tick at the end of each bit.
REQ-024 The module SHALL not instantiate the BRAM; the top-level mux connects addr and dout.

Verification
REQ-025 The bench SHALL cover these scenarios (CLKS_PER_BIT=4, TXSTR_BASE=128, one-cycle-latency BRAM model):
- BRAM[128]=0x41, start with len=1 -> TX reads 0,1,0,0,0,0,0,1,0,1 at 4 cycles per bit; done pulses once; busy stays high for the whole transfer.
- BRAM[128..130]="abc", len=3 -> a receiver model decodes 0x61 0x62 0x63; exactly 2 idle-high cycles between frames.
- start with len=0 -> done two cycles later; TX never goes low; busy high for one cycle.
- TXSTR_BASE=254, len=4 -> addresses read are 254, 255, 0, 1.
- rst asserted in the middle of the DATA bits of character 2 -> TX=1 next cycle, no done pulse; a new start with len=1 then sends normally.
- Built with UART_STR_TX_PARITY_EN, data 0x07 -> parity bit 1 and frame length 11 bits; data 0x03 -> parity bit 0.
